// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversamples sclk/cs/mosi in clk_i, shifts one LSB-first DW-bit frame per cs window.
// Optional `SPI_SLAVE_FRAME_ERR_EN adds a frame_err_o strobe for aborted or over-length frames.
module spi_slave_responder #(
  parameter int unsigned DW          = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sclk_i,
  input  logic          cs_i,
  input  logic          mosi_i,
  output logic          miso_o,
  input  logic [DW-1:0] tx_data_i,
  input  logic          tx_load_i,
  output logic          tx_busy_o,
  output logic [DW-1:0] rx_data_o,
  output logic          rx_valid_o,
  output logic          frame_err_o
);

  localparam int unsigned CntW = $clog2(DW + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone, StWaitCs} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   rise, fall, cs_fall, cs_rise;

  state_e                 state_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic [DW-1:0]          hold_q;
  logic [DW-2:0]          tx_sh_q;  // bits still to send after the one on miso
  logic [DW-2:0]          rx_sh_q;  // first DW-1 received bits; last bit goes straight to rx_data
  logic [DW-1:0]          rx_data_q;
  logic                   rx_valid_q, tx_busy_q, miso_q;

  // Chains reset low so a cs held low through reset never looks like a fresh cs_fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
    end
  end

  always_comb begin
    sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    cs_s    = cs_sync_q[SYNC_STAGES-1];
    mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    rise    = sclk_s & ~sclk_dly_q;
    fall    = ~sclk_s & sclk_dly_q;
    cs_fall = ~cs_s & cs_dly_q;
    cs_rise = cs_s & ~cs_dly_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      hold_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      // A load coinciding with cs_fall loses: the frame must use the old hold value.
      if (tx_load_i && !tx_busy_q && !(state_q == StIdle && cs_fall)) begin
        hold_q <= tx_data_i;
      end
      unique case (state_q)
        StIdle: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            tx_sh_q   <= hold_q[DW-1:1];
            miso_q    <= hold_q[0];
            bit_cnt_q <= '0;
            tx_busy_q <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (cs_rise) begin
            tx_busy_q <= 1'b0;
            miso_q    <= 1'b0;
            state_q   <= StIdle;
          end else if (rise) begin
            rx_sh_q   <= {mosi_s, rx_sh_q[DW-2:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CntW'(DW - 1)) begin
              rx_data_q  <= {mosi_s, rx_sh_q};
              rx_valid_q <= 1'b1;
              state_q    <= StDone;
            end
          end else if (fall) begin
            miso_q  <= tx_sh_q[0];
            tx_sh_q <= tx_sh_q >> 1;
          end
        end
        StDone: begin
          tx_busy_q <= 1'b0;
          miso_q    <= 1'b0;
          state_q   <= StWaitCs;
        end
        StWaitCs: begin
          miso_q <= 1'b0;
          if (cs_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= (state_q == StShift && cs_rise) || (state_q == StWaitCs && rise);
    end
  end

  assign frame_err_o = frame_err_q;
`else
  assign frame_err_o = 1'b0;
`endif

  assign miso_o     = miso_q;
  assign tx_busy_o  = tx_busy_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule
